// File: rtl/bist_scan_controller.sv
// bist_scan_controller
// Sequences a scan-based BIST session for the TRCUTwithLSFR circuit under test.
// One START pulse runs the session: load the LFSR seed, then NUM_PATTERNS
// rounds of CHAIN_LEN shift cycles each followed by one capture cycle, then a
// final CHAIN_LEN-cycle unload. The scan-out stream is compacted into a serial
// MISR and compared against a golden signature.
//
// Optional build macro BIST_GOLDEN_PORT_EN: adds input GOLDEN_IN. Its value is
// latched when START is accepted, and PASS compares against that latched value
// instead of the GOLDEN parameter.
//
// Control handshake: START is a one-cycle request that is honoured only in
// IDLE or DONE and ignored while BUSY=1. DONE then acts as the completion
// flag and stays high, with PASS valid, until the next accepted START or an
// ABORT. ABORT is a level that wins over START in the same cycle.
module bist_scan_controller #(
  parameter int                CHAIN_LEN    = 60,
  parameter int                NUM_PATTERNS = 4,
  parameter int                MISR_W       = 16,
  parameter logic [MISR_W-1:0] POLY         = 16'h1021,
  parameter logic [MISR_W-1:0] GOLDEN       = 16'h0000
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              START,
  input  logic              ABORT,
  input  logic              SO,
  output logic              SE,
  output logic              LFSR_LOAD,
  output logic              LFSR_EN,
  output logic              BUSY,
  output logic              DONE,
  output logic              PASS,
  output logic [MISR_W-1:0] SIGNATURE
`ifdef BIST_GOLDEN_PORT_EN
  ,
  input  logic [MISR_W-1:0] GOLDEN_IN
`endif
);

  localparam int SC_W = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam int PC_W = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS + 1) : 1;
  localparam logic [SC_W-1:0] SHIFT_LAST = SC_W'(CHAIN_LEN - 1);
  localparam logic [PC_W-1:0] PAT_LAST   = PC_W'(NUM_PATTERNS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INIT    = 3'd1,
    S_SHIFT   = 3'd2,
    S_CAPTURE = 3'd3,
    S_UNLOAD  = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  // FSM state register; kept as a named enum so checkers can bind to it.
  state_t            state;
  logic [SC_W-1:0]   shift_cnt;
  logic [PC_W-1:0]   pat_cnt;
  logic [MISR_W-1:0] misr;
  logic [MISR_W-1:0] misr_step;
  logic [MISR_W-1:0] golden_ref;

  assign SIGNATURE = misr;

`ifdef BIST_GOLDEN_PORT_EN
  logic [MISR_W-1:0] golden_q;

  // Latch the externally supplied golden signature when a session is accepted.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      golden_q <= '0;
    end else if (!ABORT && START && (state == S_IDLE || state == S_DONE)) begin
      golden_q <= GOLDEN_IN;
    end
  end

  assign golden_ref = golden_q;
`else
  assign golden_ref = GOLDEN;
`endif

  // One serial MISR step: shift left, fold in the polynomial on MSB-out, XOR SO into bit 0.
  always_comb begin
    misr_step = {misr[MISR_W-2:0], 1'b0}
              ^ (misr[MISR_W-1] ? POLY : '0)
              ^ {{(MISR_W-1){1'b0}}, SO};
  end

  // Session sequencer; every output is set for the state being entered.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state     <= S_IDLE;
      shift_cnt <= '0;
      pat_cnt   <= '0;
      misr      <= '0;
      SE        <= 1'b1;
      LFSR_LOAD <= 1'b0;
      LFSR_EN   <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      PASS      <= 1'b0;
    end else begin
      LFSR_LOAD <= 1'b0;
      if (ABORT) begin
        // Signature is kept so a debugger can inspect the partial result.
        state     <= S_IDLE;
        shift_cnt <= '0;
        pat_cnt   <= '0;
        SE        <= 1'b1;
        LFSR_EN   <= 1'b0;
        BUSY      <= 1'b0;
        DONE      <= 1'b0;
        PASS      <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (START) begin
              state     <= S_INIT;
              shift_cnt <= '0;
              pat_cnt   <= '0;
              misr      <= '0;
              SE        <= 1'b1;
              LFSR_LOAD <= 1'b1;
              LFSR_EN   <= 1'b0;
              BUSY      <= 1'b1;
              DONE      <= 1'b0;
              PASS      <= 1'b0;
            end
          end
          S_INIT: begin
            state   <= S_SHIFT;
            SE      <= 1'b1;
            LFSR_EN <= 1'b1;
          end
          S_SHIFT: begin
            // Pattern 0 shifts in over an unknown chain, so nothing is compacted.
            if (pat_cnt != '0) begin
              misr <= misr_step;
            end
            if (shift_cnt == SHIFT_LAST) begin
              state     <= S_CAPTURE;
              shift_cnt <= '0;
              SE        <= 1'b0;
              LFSR_EN   <= 1'b0;
            end else begin
              shift_cnt <= shift_cnt + 1'b1;
            end
          end
          S_CAPTURE: begin
            pat_cnt <= pat_cnt + 1'b1;
            SE      <= 1'b1;
            if (pat_cnt == PAT_LAST) begin
              state   <= S_UNLOAD;
              LFSR_EN <= 1'b0;
            end else begin
              state   <= S_SHIFT;
              LFSR_EN <= 1'b1;
            end
          end
          S_UNLOAD: begin
            misr <= misr_step;
            if (shift_cnt == SHIFT_LAST) begin
              // Compare the value the MISR takes on this same edge.
              state     <= S_DONE;
              shift_cnt <= '0;
              BUSY      <= 1'b0;
              DONE      <= 1'b1;
              PASS      <= (misr_step == golden_ref);
            end else begin
              shift_cnt <= shift_cnt + 1'b1;
            end
          end
          default: begin
            state   <= S_IDLE;
            SE      <= 1'b1;
            LFSR_EN <= 1'b0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            PASS    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/bist_scan_controller.md
Name: bist_scan_controller

Overview:
- Sequences scan-based BIST for the TRCUTwithLSFR circuit under test (CUT).
- Drives scan enable SE and the LFSR advance enable. Runs NUM_PATTERNS shift/capture rounds, then a final unload.
- Compacts the CUT scan-out (SO) into a serial MISR signature and compares it against a golden value, giving a pass/fail flag.
- Replaces the hand-timed SE toggling of the bench: one START pulse runs the whole session.

Parameters:
- CHAIN_LEN, 60, number of scan cells; shift cycles per pattern.
- NUM_PATTERNS, 4, number of capture cycles per session (>=1).
- MISR_W, 16, signature register width (>=2).
- POLY, 16'h1021, MISR feedback polynomial; MISR_W bits.
- GOLDEN, 16'h0000, expected signature; MISR_W bits.

Ports:
- CLK  input  1  system clock, rising edge.
- RSTn  input  1  asynchronous active-low reset.
- START  input  1  one-cycle pulse; sampled only in IDLE or DONE.
- ABORT  input  1  level; forces return to IDLE.
- SO  input  1  CUT scan-out.
- SE  output  1  scan enable to CUT: 1 = shift, 0 = capture.
- LFSR_LOAD  output  1  loads the LFSR seed (one cycle).
- LFSR_EN  output  1  advances the pattern LFSR.
- BUSY  output  1  session in progress.
- DONE  output  1  session complete; held until next START.
- PASS  output  1  valid while DONE=1: signature equals golden.
- SIGNATURE  output  MISR_W  current MISR contents.

Behaviour:
- Reset (RSTn=0, async): state IDLE, SE=1, LFSR_LOAD=0, LFSR_EN=0, BUSY=0, DONE=0, PASS=0, SIGNATURE=0, all counters 0.
- States:
  - IDLE: SE=1, BUSY=0. On START go to INIT.
  - INIT: one cycle. LFSR_LOAD=1, MISR cleared to 0, shift_cnt=0, pat_cnt=0, BUSY=1, DONE=0, PASS=0. Next state SHIFT.
  - SHIFT: SE=1, LFSR_EN=1, for exactly CHAIN_LEN cycles (shift_cnt 0..CHAIN_LEN-1). MISR compacts SO only when pat_cnt>0; pattern 0 has no valid response in the chain. On shift_cnt=CHAIN_LEN-1, go to CAPTURE.
  - CAPTURE: one cycle, SE=0, LFSR_EN=0, no compaction. pat_cnt increments. If the new pat_cnt equals NUM_PATTERNS go to UNLOAD, else go to SHIFT with shift_cnt=0.
  - UNLOAD: SE=1, LFSR_EN=0, compaction on, for CHAIN_LEN cycles. Then go to DONE.
  - DONE: BUSY=0, DONE=1, PASS=(MISR==golden) registered on entry, SE=1. START goes to INIT, which clears DONE and PASS.
- MISR step (compaction enabled): next = {misr[MISR_W-2:0],1'b0} ^ (misr[MISR_W-1] ? POLY : 0) ^ {{MISR_W-1{0}}, SO}.
- All outputs are registered. SE changes on the clock edge that enters or leaves CAPTURE, so SE is low for exactly one CLK period per pattern.
- Session length from the START cycle to the first DONE=1 cycle: 1 + NUM_PATTERNS*(CHAIN_LEN+1) + CHAIN_LEN cycles. Default is 305.
- START while BUSY=1 is ignored.
- ABORT=1 in any state moves to IDLE on the next edge: DONE=0, PASS=0, SIGNATURE retained. ABORT has priority over START in the same cycle.
- Counters saturate logically via state transitions; no wrap-around is reachable.
- Reset mid-session: immediate return to the reset values above.

Optional Feature:
- Macro: BIST_GOLDEN_PORT_EN.
- Defined: adds input GOLDEN_IN [MISR_W-1:0]. Its value is captured into an internal register on the cycle START is accepted, and PASS compares against that register; the GOLDEN parameter is unused.
- Undefined: no GOLDEN_IN port; the comparison uses the GOLDEN parameter.

Test Plan:
- Reset/idle: assert RSTn=0 mid-SHIFT -> SE=1, BUSY=0, DONE=0, PASS=0, SIGNATURE=0 with no clock edge; after release, 10 idle cycles with no START keep the same values.
- Default run, SO tied 0, GOLDEN=0: pulse START -> LFSR_LOAD high exactly 1 cycle. SE low on exactly 4 single cycles spaced 61 cycles apart. DONE=1 at cycle 305 after START, SIGNATURE=16'h0000, PASS=1.
- Small config CHAIN_LEN=2, NUM_PATTERNS=1, MISR_W=4, POLY=4'h3, GOLDEN=4'h3, SO tied 1 -> DONE after 6 cycles, SIGNATURE=4'h3, PASS=1. Same run with GOLDEN=4'h5 -> PASS=0.
- START pulsed again during SHIFT -> ignored; session length remains 305 cycles. START pulsed while DONE=1 -> DONE and PASS clear, new session begins.
- ABORT asserted during pattern 2 CAPTURE -> next cycle IDLE, SE=1, BUSY=0, DONE=0. A following START runs a full 305-cycle session.
- With BIST_GOLDEN_PORT_EN defined: drive GOLDEN_IN=16'h0000 at START, then change it to 16'hFFFF mid-session with SO=0 -> PASS=1, confirming GOLDEN_IN was latched at START.
